// File: rtl/gcd_unit_arbiter.sv
// Round-robin arbiter that shares one GCD datapath among several requesters.
// A tag FIFO remembers issue order so each result is steered back to its requester.
module gcd_unit_arbiter #(
    parameter int P_NUM_REQS = 4,
    parameter int P_MAX_INFL = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [P_NUM_REQS-1:0]         req_val_i,
    output logic [P_NUM_REQS-1:0]         req_rdy_o,
    input  logic [32*P_NUM_REQS-1:0]      req_msg_i,
    output logic [P_NUM_REQS-1:0]         resp_val_o,
    input  logic [P_NUM_REQS-1:0]         resp_rdy_i,
    output logic [15:0]                   resp_msg_o,
    output logic                          gcd_req_val_o,
    input  logic                          gcd_req_rdy_i,
    output logic [31:0]                   gcd_req_msg_o,
    input  logic                          gcd_resp_val_i,
    output logic                          gcd_resp_rdy_o,
    input  logic [15:0]                   gcd_resp_msg_i,
    output logic [$clog2(P_MAX_INFL):0]   inflight_o
);

    localparam int IDX_W = $clog2(P_NUM_REQS);
    localparam int PTR_W = $clog2(P_MAX_INFL);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] tag_mem_q [P_MAX_INFL];

    logic [IDX_W-1:0] grant;
    logic             any_val;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_tag;
    logic [31:0]      msg_arr [P_NUM_REQS];

    assign fifo_full  = (count_q == CNT_W'(P_MAX_INFL));
    assign fifo_empty = (count_q == '0);
    assign head_tag   = tag_mem_q[rd_ptr_q];

    // Scan from the highest offset down so the offset closest to rr_ptr wins.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        grant   = '0;
        any_val = 1'b0;
        for (int k = P_NUM_REQS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % P_NUM_REQS;
            if (req_val_i[idx]) begin
                grant   = IDX_W'(idx);
                any_val = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < P_NUM_REQS; gi++) begin : g_req
            assign msg_arr[gi]    = req_msg_i[32*gi +: 32];
            assign req_rdy_o[gi]  = rst_n & (grant == IDX_W'(gi)) & gcd_req_rdy_i & ~fifo_full;
            assign resp_val_o[gi] = rst_n & gcd_resp_val_i & ~fifo_empty & (head_tag == IDX_W'(gi));
        end
    endgenerate

    assign gcd_req_val_o  = rst_n & any_val & ~fifo_full;
    assign gcd_req_msg_o  = msg_arr[grant];
    assign gcd_resp_rdy_o = rst_n & ~fifo_empty & resp_rdy_i[head_tag];
    assign resp_msg_o     = gcd_resp_msg_i;
    assign inflight_o     = count_q;

    assign push = gcd_req_val_o & gcd_req_rdy_i;
    assign pop  = gcd_resp_val_i & gcd_resp_rdy_o;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            rr_ptr_d = (grant == IDX_W'(P_NUM_REQS - 1)) ? '0 : grant + IDX_W'(1);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant;
        end
    end

    // A result with no outstanding tag means the GCD unit broke the protocol.
    assert property (@(posedge clk) disable iff (!rst_n) !(gcd_resp_val_i && fifo_empty));

endmodule

// File: tb/tb_gcd_unit_arbiter.sv
// Directed bench for gcd_unit_arbiter with a behavioural GCD unit and per-requester
// source/sink models; responses are scored against hand-computed gcd values.
module tb_gcd_unit_arbiter;

    localparam int N = 4;
    localparam int M = 4;
    localparam int DEPTH = 32;

    typedef struct {
        int          req;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
    } vec_t;

    typedef struct {
        logic [15:0] g;
        int          t;
    } gres_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_val = '0;
    logic [N-1:0]    req_rdy;
    logic [32*N-1:0] req_msg = '0;
    logic [N-1:0]    resp_val;
    logic [N-1:0]    resp_rdy = '0;
    logic [15:0]     resp_msg;
    logic            gcd_req_val;
    logic            gcd_req_rdy = 1'b1;
    logic [31:0]     gcd_req_msg;
    logic            gcd_resp_val = 1'b0;
    logic            gcd_resp_rdy;
    logic [15:0]     gcd_resp_msg = '0;
    logic [$clog2(M):0] inflight;

    always #5 clk = ~clk;

    gcd_unit_arbiter #(.P_NUM_REQS(N), .P_MAX_INFL(M)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_val_i      (req_val),
        .req_rdy_o      (req_rdy),
        .req_msg_i      (req_msg),
        .resp_val_o     (resp_val),
        .resp_rdy_i     (resp_rdy),
        .resp_msg_o     (resp_msg),
        .gcd_req_val_o  (gcd_req_val),
        .gcd_req_rdy_i  (gcd_req_rdy),
        .gcd_req_msg_o  (gcd_req_msg),
        .gcd_resp_val_i (gcd_resp_val),
        .gcd_resp_rdy_o (gcd_resp_rdy),
        .gcd_resp_msg_i (gcd_resp_msg),
        .inflight_o     (inflight)
    );

    int passed = 0;
    int total  = 0;

    logic [31:0] src_mem [N][DEPTH];
    int          src_head [N];
    int          src_tail [N];
    int          src_cnt [N];
    logic [15:0] exp_mem [N][DEPTH];
    int          exp_head [N];
    int          exp_tail [N];
    int          sink_cnt [N];
    int          got_cnt [N];
    logic        fired [N];
    gres_t       gq[$];
    int          grant_log[$];
    int          cyc = 0;
    int          lat = 2;
    int          src_dly = 0;
    int          sink_dly = 0;
    logic        sink_block = 1'b0;

    vec_t v2 [4];
    vec_t v3 [8];
    vec_t v4 [5];
    vec_t v5 [20];

    function automatic void check(string name, logic [31:0] got, logic [31:0] expv);
        total++;
        if (got === expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    endfunction

    function automatic logic [15:0] gcd_ref(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] x, y, r;
        x = a_in;
        y = b_in;
        for (int k = 0; k < 64 && y != 0; k++) begin
            r = x % y;
            x = y;
            y = r;
        end
        return x;
    endfunction

    function automatic void push_vec(vec_t v);
        src_mem[v.req][src_tail[v.req]] = {v.a, v.b};
        src_tail[v.req]++;
        exp_mem[v.req][exp_tail[v.req]] = v.g;
        exp_tail[v.req]++;
    endfunction

    function automatic logic pending();
        logic p;
        p = 1'b0;
        for (int i = 0; i < N; i++)
            if (src_head[i] != src_tail[i] || exp_head[i] != exp_tail[i]) p = 1'b1;
        return p;
    endfunction

    // One clock: sample handshakes just before the edge, then drive on the falling edge.
    task automatic step();
        logic pend;
        @(posedge clk);
        if (!rst_n) begin
            gq.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                fired[i] = req_val[i] && req_rdy[i];
                if (fired[i]) begin
                    grant_log.push_back(i);
                    $display("issue req%0d a=%0d b=%0d", i, req_msg[32*i+16 +: 16], req_msg[32*i +: 16]);
                end
            end
            if (gcd_resp_val && gcd_resp_rdy) void'(gq.pop_front());
            if (gcd_req_val && gcd_req_rdy)
                gq.push_back('{gcd_ref(gcd_req_msg[31:16], gcd_req_msg[15:0]), cyc + lat});
            for (int i = 0; i < N; i++) begin
                if (resp_val[i] && resp_rdy[i]) begin
                    $display("resp  req%0d msg=%0d", i, resp_msg);
                    got_cnt[i]++;
                    pend = (exp_head[i] != exp_tail[i]);
                    check($sformatf("resp_pending_r%0d", i), 32'(pend), 1);
                    if (pend) begin
                        check($sformatf("resp_msg_r%0d", i), 32'(resp_msg), 32'(exp_mem[i][exp_head[i]]));
                        exp_head[i]++;
                    end
                    sink_cnt[i] = sink_dly;
                end
            end
            cyc++;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (fired[i]) begin
                src_head[i]++;
                src_cnt[i] = src_dly;
                fired[i] = 1'b0;
            end else if (src_cnt[i] > 0) begin
                src_cnt[i]--;
            end
            if (sink_cnt[i] > 0) sink_cnt[i]--;
            req_val[i] = (src_head[i] != src_tail[i]) && (src_cnt[i] == 0);
            req_msg[32*i +: 32] = src_mem[i][src_head[i]];
            resp_rdy[i] = !sink_block && (sink_cnt[i] == 0);
        end
        gcd_resp_val = rst_n && (gq.size() > 0) && (gq.size() > 0 ? gq[0].t <= cyc : 1'b0);
        gcd_resp_msg = (gq.size() > 0) ? gq[0].g : 16'd0;
    endtask

    task automatic run_idle(string name, int max_cyc);
        int n;
        n = 0;
        while (pending() && n < max_cyc) begin
            step();
            n++;
        end
        check({name, "_drained"}, 32'(pending()), 0);
    endtask

    task automatic wait_grants(string name, int cnt, int max_cyc);
        int n;
        n = 0;
        while (grant_log.size() < cnt && n < max_cyc) begin
            step();
            n++;
        end
        check({name, "_grants"}, grant_log.size(), cnt);
    endtask

    initial begin
        int base [N];

        v2 = '{'{0, 16'd3, 16'd9, 16'd3}, '{1, 16'd27, 16'd15, 16'd3},
               '{2, 16'd21, 16'd49, 16'd7}, '{3, 16'd25, 16'd30, 16'd5}};
        v3 = '{'{0, 16'd12, 16'd8, 16'd4}, '{2, 16'd18, 16'd24, 16'd6},
               '{0, 16'd100, 16'd75, 16'd25}, '{2, 16'd35, 16'd14, 16'd7},
               '{0, 16'd9, 16'd6, 16'd3}, '{2, 16'd13, 16'd26, 16'd13},
               '{0, 16'd14, 16'd21, 16'd7}, '{2, 16'd50, 16'd20, 16'd10}};
        v4 = '{'{0, 16'd8, 16'd12, 16'd4}, '{1, 16'd16, 16'd4, 16'd4},
               '{2, 16'd45, 16'd10, 16'd5}, '{3, 16'd7, 16'd3, 16'd1},
               '{0, 16'd60, 16'd48, 16'd12}};
        v5 = '{'{0, 16'd48, 16'd18, 16'd6}, '{1, 16'd36, 16'd60, 16'd12},
               '{2, 16'd56, 16'd98, 16'd14}, '{3, 16'd44, 16'd121, 16'd11},
               '{0, 16'd17, 16'd5, 16'd1}, '{1, 16'd121, 16'd11, 16'd11},
               '{2, 16'd30, 16'd45, 16'd15}, '{3, 16'd1, 16'd1, 16'd1},
               '{0, 16'd81, 16'd27, 16'd27}, '{1, 16'd77, 16'd33, 16'd11},
               '{2, 16'd1024, 16'd96, 16'd32}, '{3, 16'd72, 16'd54, 16'd18},
               '{0, 16'd64, 16'd40, 16'd8}, '{1, 16'd1000, 16'd250, 16'd250},
               '{2, 16'd13, 16'd17, 16'd1}, '{3, 16'd65, 16'd39, 16'd13},
               '{0, 16'd99, 16'd66, 16'd33}, '{1, 16'd14, 16'd49, 16'd7},
               '{2, 16'd90, 16'd120, 16'd30}, '{3, 16'd200, 16'd150, 16'd50}};

        for (int i = 0; i < N; i++) begin
            src_head[i] = 0; src_tail[i] = 0; src_cnt[i] = 0;
            exp_head[i] = 0; exp_tail[i] = 0; sink_cnt[i] = 0;
            got_cnt[i] = 0; fired[i] = 1'b0;
        end

        // Reset: outputs gated even with every requester asserting valid.
        req_val  = '1;
        resp_rdy = '1;
        repeat (3) @(negedge clk);
        check("rst_inflight", 32'(inflight), 0);
        check("rst_gcd_req_val", 32'(gcd_req_val), 0);
        check("rst_req_rdy", 32'(req_rdy), 0);
        check("rst_resp_val", 32'(resp_val), 0);
        check("rst_gcd_resp_rdy", 32'(gcd_resp_rdy), 0);
        req_val = '0;
        rst_n = 1'b1;
        step();

        // All four requesters at once: grant order 0,1,2,3 from a reset pointer.
        grant_log.delete();
        for (int k = 0; k < 4; k++) push_vec(v2[k]);
        wait_grants("t2", 4, 20);
        for (int k = 0; k < 4; k++)
            if (k < grant_log.size()) check($sformatf("t2_grant%0d", k), grant_log[k], k);
        run_idle("t2", 50);

        // Single request from requester 0.
        grant_log.delete();
        base[0] = got_cnt[0];
        push_vec('{0, 16'd15, 16'd5, 16'd5});
        wait_grants("t1", 1, 20);
        check("t1_inflight_busy", 32'(inflight), 1);
        run_idle("t1", 50);
        check("t1_inflight_idle", 32'(inflight), 0);
        check("t1_resp_count", got_cnt[0] - base[0], 1);

        // Fairness: requesters 0 and 2 continuously valid must alternate.
        grant_log.delete();
        for (int k = 0; k < 8; k++) push_vec(v3[k]);
        wait_grants("t3", 8, 100);
        for (int k = 1; k < 8; k++)
            if (k < grant_log.size())
                check($sformatf("t3_alt%0d", k), grant_log[k] + grant_log[k-1], 2);
        run_idle("t3", 100);

        // Backpressure: responses blocked, exactly M requests issue.
        grant_log.delete();
        sink_block = 1'b1;
        for (int k = 0; k < 5; k++) push_vec(v4[k]);
        repeat (20) step();
        check("t4_fires_when_full", grant_log.size(), M);
        check("t4_inflight_full", 32'(inflight), M);
        check("t4_req_rdy_full", 32'(req_rdy), 0);
        check("t4_gcd_req_val_full", 32'(gcd_req_val), 0);
        check("t4_waiting", 32'(req_val != '0), 1);
        sink_block = 1'b0;
        run_idle("t4", 100);
        check("t4_fires_after_drain", grant_log.size(), 5);

        // Source and sink delays with mixed traffic over all requesters.
        src_dly  = 3;
        sink_dly = 3;
        lat      = 3;
        for (int i = 0; i < N; i++) base[i] = got_cnt[i];
        for (int k = 0; k < 20; k++) push_vec(v5[k]);
        run_idle("t5", 2000);
        for (int i = 0; i < N; i++)
            check($sformatf("t5_resp_count_r%0d", i), got_cnt[i] - base[i], 5);
        src_dly  = 0;
        sink_dly = 0;

        // Reset with two requests outstanding.
        lat = 50;
        grant_log.delete();
        push_vec('{0, 16'd6, 16'd4, 16'd2});
        push_vec('{3, 16'd9, 16'd3, 16'd3});
        wait_grants("t6", 2, 20);
        check("t6_inflight_busy", 32'(inflight), 2);
        rst_n = 1'b0;
        gcd_resp_val = 1'b0;
        #1;
        check("t6_rst_inflight", 32'(inflight), 0);
        check("t6_rst_resp_val", 32'(resp_val), 0);
        check("t6_rst_gcd_req_val", 32'(gcd_req_val), 0);
        for (int i = 0; i < N; i++) begin
            src_head[i] = src_tail[i];
            exp_head[i] = exp_tail[i];
            got_cnt[i]  = 0;
        end
        gq.delete();
        step();
        step();
        rst_n = 1'b1;
        lat = 2;
        push_vec('{1, 16'd40, 16'd40, 16'd40});
        run_idle("t6", 50);
        for (int i = 0; i < N; i++)
            check($sformatf("t6_resp_only_r1_%0d", i), got_cnt[i], (i == 1) ? 1 : 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
